// File: rtl/uart_cmd_master.sv
// rtl/uart_cmd_master.sv - host-side UART command initiator: frames a command, collects the response.
module uart_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_type,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH-1:0]   cmd_op_a,
  input  logic [DATA_WIDTH-1:0]   cmd_op_b,
  input  logic [FUN_WIDTH-1:0]    cmd_fun,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic                    rx_unexp
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  localparam logic [1:0] T_WR  = 2'd0;
  localparam logic [1:0] T_RD  = 2'd1;
  localparam logic [1:0] T_OP  = 2'd2;
  localparam logic [1:0] T_NOP = 2'd3;

  localparam logic [DATA_WIDTH-1:0] HDR_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] HDR_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] HDR_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] HDR_NOP = DATA_WIDTH'(8'hDD);

  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   frame_q [4];
  logic [DATA_WIDTH-1:0]   frame_d [4];
  logic [1:0]              last_idx_q, last_idx_d;
  logic [1:0]              n_rsp_q, n_rsp_d;
  logic [1:0]              byte_idx_q;
  logic [1:0]              rx_cnt_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    cmd_ready_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic                    tx_valid_q;
  logic [2*DATA_WIDTH-1:0] rsp_data_q;
  logic                    rsp_valid_q;
  logic                    rsp_err_q;
  logic                    rx_unexp_q;
  logic [1:0]              next_idx;

  assign cmd_ready = cmd_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rx_unexp  = rx_unexp_q;
  assign next_idx  = byte_idx_q + 2'd1;

  // Frame image and response length derived from the live command inputs; captured on accept.
  always_comb begin
    frame_d[0] = '0;
    frame_d[1] = '0;
    frame_d[2] = '0;
    frame_d[3] = '0;
    last_idx_d = 2'd0;
    n_rsp_d    = 2'd0;
    case (cmd_type)
      T_WR: begin
        frame_d[0] = HDR_WR;
        frame_d[1] = DATA_WIDTH'(cmd_addr);
        frame_d[2] = cmd_data;
        last_idx_d = 2'd2;
        n_rsp_d    = 2'd0;
      end
      T_RD: begin
        frame_d[0] = HDR_RD;
        frame_d[1] = DATA_WIDTH'(cmd_addr);
        last_idx_d = 2'd1;
        n_rsp_d    = 2'd1;
      end
      T_OP: begin
        frame_d[0] = HDR_OP;
        frame_d[1] = cmd_op_a;
        frame_d[2] = cmd_op_b;
        frame_d[3] = DATA_WIDTH'(cmd_fun);
        last_idx_d = 2'd3;
        n_rsp_d    = 2'd2;
      end
      default: begin
        frame_d[0] = HDR_NOP;
        frame_d[1] = DATA_WIDTH'(cmd_fun);
        last_idx_d = 2'd1;
        n_rsp_d    = 2'd2;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      frame_q[0]  <= '0;
      frame_q[1]  <= '0;
      frame_q[2]  <= '0;
      frame_q[3]  <= '0;
      last_idx_q  <= '0;
      n_rsp_q     <= '0;
      byte_idx_q  <= '0;
      rx_cnt_q    <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rx_unexp_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rx_unexp_q  <= rx_valid && (state_q != WAIT_RSP);
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            frame_q[0]  <= frame_d[0];
            frame_q[1]  <= frame_d[1];
            frame_q[2]  <= frame_d[2];
            frame_q[3]  <= frame_d[3];
            last_idx_q  <= last_idx_d;
            n_rsp_q     <= n_rsp_d;
            byte_idx_q  <= 2'd0;
            tx_data_q   <= frame_d[0];
            tx_valid_q  <= 1'b1;
            rsp_data_q  <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (tx_valid_q && tx_ready) begin
            if (byte_idx_q == last_idx_q) begin
              tx_valid_q <= 1'b0;
              if (n_rsp_q == 2'd0) begin
                rsp_data_q  <= '0;
                rsp_valid_q <= 1'b1;
                state_q     <= DONE;
              end else begin
                cnt_q    <= '0;
                rx_cnt_q <= 2'd0;
                state_q  <= WAIT_RSP;
              end
            end else begin
              byte_idx_q <= next_idx;
              tx_data_q  <= frame_q[next_idx];
            end
          end
        end
        WAIT_RSP: begin
          // A byte arriving on the expiry cycle takes priority over the timeout.
          if (rx_valid) begin
            cnt_q <= '0;
            if (rx_cnt_q == 2'd0) begin
              rsp_data_q[DATA_WIDTH-1:0] <= rx_data;
            end else begin
              rsp_data_q[2*DATA_WIDTH-1:DATA_WIDTH] <= rx_data;
            end
            if (rx_cnt_q + 2'd1 == n_rsp_q) begin
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              rx_cnt_q <= rx_cnt_q + 2'd1;
            end
          end else if (cnt_q == TO_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb/tb_uart_cmd_master.sv - directed bench for uart_cmd_master with a 16-cycle response timeout.
module tb_uart_cmd_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'd0;
  logic [3:0]  cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic [7:0]  cmd_op_a = '0;
  logic [7:0]  cmd_op_b = '0;
  logic [3:0]  cmd_fun = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_err;
  logic        rx_unexp;

  int vec  = 0;
  int errs = 0;

  uart_cmd_master #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_op_a(cmd_op_a),
    .cmd_op_b(cmd_op_b), .cmd_fun(cmd_fun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rx_unexp(rx_unexp)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] f);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_op_a  = opa;
    cmd_op_b  = opb;
    cmd_fun   = f;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rsp", {13'd0, rsp_valid, rsp_err, rx_unexp, rsp_data}, 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    RST = 1'b1;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    rx_byte(8'h55);
    chk("idle_rx_unexp", 32'(rx_unexp), 32'd1);
    chk("idle_ready_kept", 32'(cmd_ready), 32'd1);
    tick();
    chk("idle_rx_unexp_clr", 32'(rx_unexp), 32'd0);

    // WR addr=4 data=3C
    tx_ready = 1'b1;
    issue(2'd0, 4'h4, 8'h3C, 8'h00, 8'h00, 4'h0);
    chk("wr_b0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hAA});
    chk("wr_busy", 32'(cmd_ready), 32'd0);
    tick();
    chk("wr_b1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h04});
    tick();
    chk("wr_b2", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h3C});
    tick();
    chk("wr_done", {13'd0, tx_valid, rsp_valid, rsp_err, rsp_data}, {13'd0, 1'b0, 1'b1, 1'b0, 16'h0000});
    tick();
    chk("wr_idle", {30'd0, rsp_valid, cmd_ready}, {30'd0, 1'b0, 1'b1});

    // RD addr=2, response 5A
    issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
    chk("rd_b0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hBB});
    tick();
    chk("rd_b1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h02});
    tick();
    chk("rd_wait", {30'd0, tx_valid, rsp_valid}, 32'd0);
    rx_byte(8'h5A);
    chk("rd_rsp", {14'd0, rsp_valid, rsp_err, rsp_data}, {14'd0, 1'b1, 1'b0, 16'h005A});
    tick();
    chk("rd_idle", {14'd0, rsp_valid, cmd_ready, rsp_data}, {14'd0, 1'b0, 1'b1, 16'h005A});

    // ALU_OP A=12 B=34 fun=1, response 46,00
    issue(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1);
    chk("op_b0", 32'(tx_data), 32'hCC);
    tick();
    chk("op_b1", 32'(tx_data), 32'h12);
    tick();
    chk("op_b2", 32'(tx_data), 32'h34);
    tick();
    chk("op_b3", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h01});
    tick();
    chk("op_wait", 32'(tx_valid), 32'd0);
    rx_byte(8'h46);
    chk("op_partial", 32'(rsp_valid), 32'd0);
    rx_byte(8'h00);
    chk("op_rsp", {14'd0, rsp_valid, rsp_err, rsp_data}, {14'd0, 1'b1, 1'b0, 16'h0046});
    tick();

    // ALU_NOP fun=3, one byte then silence; cmd_valid during the wait is ignored
    issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3);
    chk("nop_b0", 32'(tx_data), 32'hDD);
    tick();
    chk("nop_b1", 32'(tx_data), 32'h03);
    tick();
    rx_byte(8'h77);
    cmd_valid = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    cmd_valid = 1'b0;
    chk("nop_no_early_to", {29'd0, tx_valid, rsp_valid, cmd_ready}, 32'd0);
    tick();
    chk("nop_timeout", {14'd0, rsp_valid, rsp_err, rsp_data}, {14'd0, 1'b1, 1'b1, 16'h0077});
    tick();
    chk("nop_idle", {30'd0, rsp_valid, rsp_err}, 32'd0);

    // ALU_OP with stalls and an unexpected rx byte during SEND
    issue(2'd2, 4'h0, 8'h00, 8'h9A, 8'hBC, 4'hF);
    chk("st_b0", 32'(tx_data), 32'hCC);
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    tick();
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    chk("st_b1", {22'd0, rx_unexp, tx_valid, tx_data}, {22'd0, 1'b1, 1'b1, 8'h9A});
    tick();
    chk("st_hold1", {22'd0, rx_unexp, tx_valid, tx_data}, {22'd0, 1'b0, 1'b1, 8'h9A});
    tick();
    chk("st_hold2", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h9A});
    tx_ready = 1'b1;
    tick();
    chk("st_b2", 32'(tx_data), 32'hBC);
    tx_ready = 1'b0;
    tick();
    chk("st_hold3", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hBC});
    tx_ready = 1'b1;
    tick();
    chk("st_b3", 32'(tx_data), 32'h0F);
    tick();
    chk("st_wait", {31'd0, tx_valid}, 32'd0);
    rx_byte(8'h11);
    rx_byte(8'h22);
    chk("st_rsp", {14'd0, rsp_valid, rsp_err, rsp_data}, {14'd0, 1'b1, 1'b0, 16'h2211});
    tick();

    // Reset after two bytes of an ALU_OP
    issue(2'd2, 4'h0, 8'h00, 8'h01, 8'h02, 4'h3);
    tick();
    chk("rst_mid_b1", 32'(tx_data), 32'h01);
    tick();
    chk("rst_mid_b2", 32'(tx_data), 32'h02);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("rst_mid_abort", {29'd0, tx_valid, rsp_valid, cmd_ready}, 32'd0);
    tick();
    chk("rst_mid_ready", {30'd0, rsp_valid, cmd_ready}, {30'd0, 1'b0, 1'b1});
    issue(2'd1, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0);
    chk("rd2_b0", 32'(tx_data), 32'hBB);
    tick();
    chk("rd2_b1", 32'(tx_data), 32'h07);
    tick();
    rx_byte(8'h99);
    chk("rd2_rsp", {14'd0, rsp_valid, rsp_err, rsp_data}, {14'd0, 1'b1, 1'b0, 16'h0099});
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
